// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for mem_port_arbiter: the transaction FSM state encoding
// and the width of the saturating out-of-window error counter.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  // Transaction FSM. The encoding is fixed so that the state register can be
  // inspected directly in emulation captures.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDWAIT = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Width of the saturating out-of-window request counter.
  localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every signal of mem_port_arbiter except clk/rst.
//   request channel  : req_valid/req_ready/req_write/req_addr/req_wdata
//                      (requester i occupies slice i of each packed vector)
//   response channel : resp_valid/resp_ready per requester, plus shared
//                      resp_err/resp_rdata for the current owner
//   mem read port    : mem_ren/mem_raddr out, mem_rdata in (synchronous read)
//   mem write port   : mem_wen/mem_waddr/mem_wdata out
//   status           : err_count (saturating out-of-window count)
// Modports: slave = arbiter side, master = requesters + memory side.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned AW    = 6,
  parameter int unsigned NREQ  = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_write;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;

  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic                  resp_err;
  logic [WIDTH-1:0]      resp_rdata;

  logic                  mem_ren;
  logic [AW-1:0]         mem_raddr;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_wen;
  logic [AW-1:0]         mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;

  logic [ERR_CNT_W-1:0]  err_count;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, err_count
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, err_count
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: grants the first asserted request
// at or after position ptr_i, wrapping modulo N.
//   req_i       : request vector
//   ptr_i       : highest-priority position this cycle (must be < N)
//   grant_o     : one-hot grant, all zero when no request is asserted
//   grant_idx_o : index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] idx;
  logic          found;

  // NOTE: every variable written here gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = IW'((int'(ptr_i) + k) % int'(N));
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous-read memory between NREQ requesters.
// Requests are arbitrated round-robin, checked against the memory's
// [OFFSET, OFFSET+DEPTH) window and either forwarded to the memory port or
// answered with an error response. One transaction is in flight at a time.
//   clk : sole clock
//   rst : synchronous, active-high reset
//   bus : mem_port_arbiter_if.slave (request/response channels, memory read
//         and write ports, err_count)
// Latency: write/error accepted in T -> resp_valid from T+1;
//          read accepted in T, mem_ren in T -> resp_valid from T+2.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 80,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned OFFSET = 32,
  parameter int unsigned AW     = 6,
  parameter int unsigned NREQ   = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Window bounds one bit wider than the address so OFFSET+DEPTH may equal
  // 2**AW without wrapping to zero.
  localparam logic [AW:0] WIN_LO = (AW+1)'(OFFSET);
  localparam logic [AW:0] WIN_HI = (AW+1)'(OFFSET + DEPTH);

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [NREQ-1:0]      arb_req;
  logic [NREQ-1:0]      grant;
  logic [IW-1:0]        grant_idx;
  logic                 accept;
  logic [AW-1:0]        sel_addr;
  logic                 sel_write;
  logic [WIDTH-1:0]     sel_wdata;
  logic                 in_window;
  logic                 mem_ren_c;
  logic                 mem_wen_c;

  // Requests are only visible to the arbiter in IDLE, so req_ready is zero
  // in RDWAIT/RESP without extra gating.
  assign arb_req = (state_q == IDLE) ? bus.req_valid : '0;

  rr_arbiter #(.N(NREQ)) u_rr_arbiter (
    .req_i       (arb_req),
    .ptr_i       (rr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Grant is only ever given to a valid requester, so a grant is a handshake.
  assign accept        = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    sel_addr  = bus.req_addr[int'(grant_idx)*int'(AW) +: AW];
    sel_wdata = bus.req_wdata[int'(grant_idx)*int'(WIDTH) +: WIDTH];
    sel_write = bus.req_write[grant_idx];
    in_window = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);
  end

  // Memory strobes are single-cycle pulses in the accept cycle. The address
  // goes out unmodified; the memory removes OFFSET itself.
  assign mem_ren_c     = accept && in_window && !sel_write;
  assign mem_wen_c     = accept && in_window &&  sel_write;
  assign bus.mem_ren   = mem_ren_c;
  assign bus.mem_raddr = mem_ren_c ? sel_addr  : '0;
  assign bus.mem_wen   = mem_wen_c;
  assign bus.mem_waddr = mem_wen_c ? sel_addr  : '0;
  assign bus.mem_wdata = mem_wen_c ? sel_wdata : '0;

  assign bus.resp_valid = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign bus.err_count  = err_count_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant_idx;
          rr_d    = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
          err_d   = !in_window;
          rdata_d = '0;
          if (!in_window) begin
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            state_d = RESP;
          end else if (sel_write) begin
            state_d = RESP;
          end else begin
            state_d = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        // Synchronous-read data is valid the cycle after mem_ren.
        rdata_d = bus.mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        // Only the owner's resp_ready can complete the response.
        if (bus.resp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural synchronous-read
// memory, a reference memory image and a queue of expected responses.
// A second instance with AW = 7 covers the address just above the window.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int WIDTH  = 80;
  localparam int DEPTH  = 32;
  localparam int OFFSET = 32;
  localparam int AW     = 6;
  localparam int NREQ   = 2;

  typedef struct {
    int               owner;
    logic             err;
    logic             is_read;
    logic [WIDTH-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(WIDTH), .AW(AW), .NREQ(NREQ)) bus ();
  mem_port_arbiter_if #(.WIDTH(WIDTH), .AW(7),  .NREQ(NREQ)) bus7 ();

  mem_port_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .OFFSET(OFFSET), .AW(AW), .NREQ(NREQ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_port_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .OFFSET(OFFSET), .AW(7), .NREQ(NREQ)
  ) dut7 (
    .clk (clk),
    .rst (rst),
    .bus (bus7)
  );

  // Behavioural memory: synchronous read, OFFSET removed inside the memory.
  logic [WIDTH-1:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wen) mem_arr[int'(bus.mem_waddr) - OFFSET] <= bus.mem_wdata;
    if (bus.mem_ren) bus.mem_rdata <= mem_arr[int'(bus.mem_raddr) - OFFSET];
  end
  assign bus7.mem_rdata = '0;

  logic [WIDTH-1:0] ref_mem [int];
  exp_t             sb [$];
  int               total = 0;
  int               bad   = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transaction on requester r; assumes the response channel
  // readiness has already been set by the caller.
  task automatic do_txn(input string name, input int r, input logic wr,
                        input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd);
    int   waited;
    int   lat;
    logic win;
    exp_t e;
    @(negedge clk);
    bus.req_valid[r]             = 1'b1;
    bus.req_write[r]             = wr;
    bus.req_addr[r*AW +: AW]     = addr;
    bus.req_wdata[r*WIDTH +: WIDTH] = wd;
    #1;
    waited = 0;
    while (!bus.req_ready[r] && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check({name, "_req_ready"}, 128'(bus.req_ready[r]), 128'(1));
    if (!bus.req_ready[r]) begin
      bus.req_valid[r] = 1'b0;
      return;
    end
    win = (int'(addr) >= OFFSET) && (int'(addr) < OFFSET + DEPTH);
    check({name, "_mem_wen"}, 128'(bus.mem_wen), 128'(wr && win));
    check({name, "_mem_ren"}, 128'(bus.mem_ren), 128'(!wr && win));
    if (wr && win) begin
      check({name, "_waddr"}, 128'(bus.mem_waddr), 128'(addr));
      check({name, "_wdata"}, 128'(bus.mem_wdata), 128'(wd));
    end
    if (!wr && win) check({name, "_raddr"}, 128'(bus.mem_raddr), 128'(addr));
    e.owner   = r;
    e.err     = !win;
    e.is_read = !wr && win;
    e.rdata   = '0;
    if (!wr && win && ref_mem.exists(int'(addr))) e.rdata = ref_mem[int'(addr)];
    if (wr && win) ref_mem[int'(addr)] = wd;
    sb.push_back(e);

    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    #1;
    lat = 1;
    while (!bus.resp_valid[r] && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check({name, "_latency"}, 128'(lat), 128'(e.is_read ? 2 : 1));
    check({name, "_resp_valid"}, 128'(bus.resp_valid), 128'(1 << e.owner));
    check({name, "_resp_err"}, 128'(bus.resp_err), 128'(e.err));
    check({name, "_resp_rdata"}, 128'(bus.resp_rdata), 128'(e.rdata));
  endtask

  initial begin
    int gid [$];
    int gcyc [$];

    for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;
    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.req_write   = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.resp_ready  = '1;
    bus7.req_valid  = '0;
    bus7.req_write  = '0;
    bus7.req_addr   = '0;
    bus7.req_wdata  = '0;
    bus7.resp_ready = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst_req_ready",  128'(bus.req_ready),  128'(0));
    check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rst_resp_err",   128'(bus.resp_err),   128'(0));
    check("rst_resp_rdata", 128'(bus.resp_rdata), 128'(0));
    check("rst_mem_ren",    128'(bus.mem_ren),    128'(0));
    check("rst_mem_wen",    128'(bus.mem_wen),    128'(0));
    check("rst_err_count",  128'(bus.err_count),  128'(0));

    // Write then read back.
    do_txn("wr40", 0, 1'b1, 6'd40, 80'h1234);
    do_txn("rd40", 0, 1'b0, 6'd40, '0);

    // Out-of-window read and write.
    do_txn("rd31", 0, 1'b0, 6'd31, '0);
    do_txn("wr0",  1, 1'b1, 6'd0,  80'hdead);
    check("oow_err_count", 128'(bus.err_count), 128'(2));

    // Window edges.
    do_txn("wr32", 0, 1'b1, 6'd32, 80'haaaa_0000_0000_0000_5555);
    do_txn("wr63", 1, 1'b1, 6'd63, 80'h0123_4567_89ab_cdef_0f0f);
    do_txn("rd32", 1, 1'b0, 6'd32, '0);
    do_txn("rd63", 0, 1'b0, 6'd63, '0);
    check("edge_err_count", 128'(bus.err_count), 128'(2));

    // Backpressure on R1; R0's resp_ready stays high and must be ignored.
    bus.resp_ready = 2'b01;
    do_txn("bp_rd40", 1, 1'b0, 6'd40, '0);
    bus.req_valid[0] = 1'b1;
    bus.req_write[0] = 1'b1;
    bus.req_addr[0 +: AW] = 6'd50;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("bp_resp_valid", 128'(bus.resp_valid), 128'(2'b10));
      check("bp_resp_rdata", 128'(bus.resp_rdata), 128'(80'h1234));
      check("bp_req_ready",  128'(bus.req_ready),  128'(0));
    end
    bus.resp_ready = 2'b11;
    @(negedge clk); #1;
    check("bp_release_valid", 128'(bus.resp_valid), 128'(0));
    check("bp_release_grant", 128'(bus.req_ready),  128'(2'b01));
    bus.req_valid = '0;

    // Reset while in RDWAIT (R0 accepted, so rr points at R1 beforehand).
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    bus.req_write    = '0;
    bus.req_addr[0 +: AW] = 6'd40;
    #1;
    check("rstrd_accept", 128'(bus.req_ready), 128'(2'b01));
    @(negedge clk);
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    check("rstrd_rdwait_ready", 128'(bus.req_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstrd_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rstrd_rr_zero",    128'(bus.req_ready),  128'(2'b01));
    check("rstrd_err_count",  128'(bus.err_count),  128'(0));
    bus.req_valid = '0;

    // Contention: both requesters hold valid writes from reset.
    do_reset();
    @(negedge clk);
    bus.req_write = 2'b11;
    bus.req_addr  = {6'd34, 6'd33};
    bus.req_wdata = {80'h22, 80'h11};
    bus.req_valid = 2'b11;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (bus.req_ready == 2'b01) begin gid.push_back(0); gcyc.push_back(c); end
      else if (bus.req_ready == 2'b10) begin gid.push_back(1); gcyc.push_back(c); end
      else if (bus.req_ready != 2'b00) begin gid.push_back(9); gcyc.push_back(c); end
      @(negedge clk); #1;
    end
    bus.req_valid = '0;
    check("cont_grants", 128'(gid.size()), 128'(6));
    for (int k = 0; k < 4 && k < gid.size(); k++)
      check($sformatf("cont_grant%0d", k), 128'(gid[k]), 128'(k % 2));
    for (int k = 1; k < gcyc.size(); k++)
      check($sformatf("cont_gap%0d", k), 128'(gcyc[k] - gcyc[k-1]), 128'(2));
    repeat (3) @(negedge clk);

    // AW = 7 instance: 64 is just above the window, 63 just inside.
    @(negedge clk);
    bus7.req_valid = 2'b01;
    bus7.req_write = '0;
    bus7.req_addr[0 +: 7] = 7'd64;
    #1;
    check("aw7_64_ready", 128'(bus7.req_ready), 128'(2'b01));
    check("aw7_64_ren",   128'(bus7.mem_ren),   128'(0));
    @(negedge clk);
    bus7.req_valid = '0;
    #1;
    check("aw7_64_valid", 128'(bus7.resp_valid), 128'(2'b01));
    check("aw7_64_err",   128'(bus7.resp_err),   128'(1));
    check("aw7_64_rdata", 128'(bus7.resp_rdata), 128'(0));
    check("aw7_64_count", 128'(bus7.err_count),  128'(1));
    @(negedge clk);
    bus7.req_valid = 2'b01;
    bus7.req_addr[0 +: 7] = 7'd63;
    #1;
    check("aw7_63_ren",   128'(bus7.mem_ren),   128'(1));
    check("aw7_63_raddr", 128'(bus7.mem_raddr), 128'(63));
    @(negedge clk);
    bus7.req_valid = '0;
    repeat (3) @(negedge clk);
    check("aw7_63_count", 128'(bus7.err_count), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
